rd_port_arbiter: RTL and testbench
==================================

// Module: rd_port_arbiter
// PURPOSE
//  Read-side scheduler for the async FIFO, in the rclk domain.
//  - Shares the single FIFO read port (rinc/rdata/rempty) between NREQ consumers.
//  - Round-robin grants; each grant is a burst of up to BURST pops.
//  - Sole driver of the read-pointer block's rinc.
// PARAMETERS
//  DATA  8   FIFO word width
//  NREQ  4   number of consumers (>=2)
//  BURST 4   max pops per grant (>=1, <=2**CW-1)
//  CW    3   burst/timeout counter width
//  TMO   6   consecutive empty cycles in XFER before the grant is released (<=2**CW-1)
// PORTS
//  rclk       in   1      read-domain clock
//  rrst_n     in   1      reset; one clock; reset is synchronous and active-low
//  rempty     in   1      FIFO empty flag (registered, from read-pointer block)
//  rdata      in   DATA   FIFO read data, valid combinationally while !rempty
//  rinc       out  1      pop request to read-pointer block
//  req        in   NREQ   consumer requests, level, one bit per consumer
//  rdy        in   NREQ   consumer accepts the word this cycle
//  grant      out  NREQ   registered one-hot grant, all-zero when idle
//  dout       out  DATA   = rdata, broadcast to all consumers
//  dvalid     out  NREQ   per-consumer word valid
//  busy       out  1      state != IDLE
//  burst_done out  1      1-cycle pulse in GAP
// BEHAVIOUR
//  Reset (rrst_n==0 at a rclk edge):
//   - state=IDLE; grant=0; cnt=0; tmo=0; burst_done=0.
//   - last=NREQ-1, so index 0 wins first.
//   - Combinational outputs follow: rinc=0, dvalid=0, busy=0.
//   - Reset mid-burst aborts at that edge; no rinc in the reset cycle.
//  FSM states: IDLE, XFER, GAP.
//   - IDLE: if |req, winner = first set req index scanning last+1, last+2, ... mod NREQ.
//     Next edge: grant<=onehot(winner), cnt<=0, tmo<=0, ->XFER. Otherwise stay in IDLE.
//   - XFER (g = granted index):
//     dvalid[g] = !rempty & req[g]; other dvalid bits = 0.
//     rinc = !rempty & req[g] & rdy[g]. rinc is never asserted while rempty.
//     On rinc: cnt++, tmo<=0. On rempty: tmo++.
//     Go to GAP when any of:
//       (a) rinc & cnt==BURST-1 (last beat popped);
//       (b) !req[g] (no pop that cycle);
//       (c) rempty & tmo==TMO-1.
//   - GAP: grant<=0, last<=g, burst_done=1, rinc=0, then ->IDLE.
//     Turnaround is fixed at 1 cycle; IDLE arbitrates on the following cycle.
//  Latency:
//   - Grant appears 1 cycle after req is sampled in IDLE.
//   - Data is zero-latency: the popped word is on dout in the same cycle as rinc.
//   - Minimum grant-to-grant gap: 2 cycles (GAP + IDLE).
//  Boundaries:
//   - rempty rises mid-burst: stall, hold grant, no pops; the timeout rule applies.
//   - req[g] and rdy[g] drop together: no pop; exit per (b).
//   - Last beat and FIFO going empty on the same cycle: exit per (a); the word is delivered.
//   - Requests from non-granted consumers are ignored until IDLE.
//   - A single requester is re-granted after GAP (no starvation lock).
//   - cnt/tmo are CW bits and saturate; they never wrap inside a burst.
// STRUCTURE
//  - Shared package fifo_ctrl_pkg: state encoding (IDLE=2'd0, XFER=2'd1, GAP=2'd2) and default widths.
//  - Sub-module rr_pick: combinational, inputs req[NREQ] and last index, outputs one-hot winner and valid.
//  - Top: FSM, counters, output gating.
// TESTING
//  1. Reset: hold rrst_n=0 for 3 clocks with req=4'b1111 -> grant=0, rinc=0, busy=0; after release, grant=4'b0001 one cycle later.
//  2. Round-robin: req=4'b1111 constant, FIFO prefilled with 16 words, rdy=all 1 -> grants 0001,0010,0100,1000,0001...; 4 pops each; burst_done every 6 cycles.
//  3. Empty stall/timeout: grant consumer 2, FIFO holds 1 word -> 1 pop, then 6 empty cycles -> GAP; rinc never high while rempty.
//  4. Request drop: consumer 1 drops req after 2 pops -> exit with cnt=2, no 3rd pop, next grant goes to index 2.
//  5. Backpressure: rdy[0] toggles 1,0,1,0 with FIFO non-empty -> exactly 4 pops over 8 cycles; dvalid[0] high throughout.
//  6. Mid-burst reset: assert rrst_n=0 during beat 2 -> next state IDLE, last=NREQ-1, no extra rinc; scoreboard shows no lost or duplicated words.

Source files
------------

// File: rtl/fifo_ctrl_pkg.sv
// Shared definitions for the async FIFO control blocks:
// FSM state encoding and default widths/limits.
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int DATA_W  = 8;
  localparam int NREQ_N  = 4;
  localparam int BURST_N = 4;
  localparam int CNT_W   = 3;
  localparam int TMO_N   = 6;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set request scanning last+1, last+2, ... mod NREQ.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int LW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [LW-1:0]   last,
  output logic [NREQ-1:0] winner,
  output logic            valid
);

  logic [LW-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    idx    = '0;
    for (int i = 1; i <= NREQ; i++) begin
      idx = LW'((int'(last) + i) % NREQ);
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rd_port_arbiter.sv
// Read-side scheduler: shares the FIFO read port between NREQ consumers with
// round-robin burst grants. Sole driver of rinc.
module rd_port_arbiter
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA  = DATA_W,
  parameter int NREQ  = NREQ_N,
  parameter int BURST = BURST_N,
  parameter int CW    = CNT_W,
  parameter int TMO   = TMO_N
) (
  input  logic            rclk,
  input  logic            rrst_n,
  input  logic            rempty,
  input  logic [DATA-1:0] rdata,
  output logic            rinc,
  input  logic [NREQ-1:0] req,
  input  logic [NREQ-1:0] rdy,
  output logic [NREQ-1:0] grant,
  output logic [DATA-1:0] dout,
  output logic [NREQ-1:0] dvalid,
  output logic            busy,
  output logic            burst_done
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [CW-1:0] CMAX = {CW{1'b1}};

  state_t          state;
  logic [LW-1:0]   last;
  logic [LW-1:0]   gidx;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   tmo;
  logic [NREQ-1:0] win;
  logic            win_valid;
  logic [LW-1:0]   win_idx;
  logic            req_g;
  logic            rdy_g;
  logic            xfer_ok;

  rr_pick #(
    .NREQ (NREQ),
    .LW   (LW)
  ) u_pick (
    .req    (req),
    .last   (last),
    .winner (win),
    .valid  (win_valid)
  );

  always_comb begin
    win_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win[i]) win_idx = LW'(i);
    end
  end

  assign req_g = req[gidx];
  assign rdy_g = rdy[gidx];

  // Gated by rrst_n so a reset mid-burst never pops in the reset cycle.
  assign xfer_ok = rrst_n && (state == XFER) && !rempty && req_g;
  assign rinc    = xfer_ok && rdy_g;
  assign dvalid  = xfer_ok ? grant : '0;
  assign dout    = rdata;
  assign busy    = (state != IDLE);

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      state      <= IDLE;
      grant      <= '0;
      gidx       <= '0;
      cnt        <= '0;
      tmo        <= '0;
      burst_done <= 1'b0;
      last       <= LW'(NREQ - 1);
    end else begin
      case (state)
        IDLE: begin
          burst_done <= 1'b0;
          if (win_valid) begin
            grant <= win;
            gidx  <= win_idx;
            cnt   <= '0;
            tmo   <= '0;
            state <= XFER;
          end
        end
        XFER: begin
          if (rinc) begin
            if (cnt != CMAX) cnt <= cnt + CW'(1);
            tmo <= '0;
            if (cnt == CW'(BURST - 1)) begin
              state      <= GAP;
              burst_done <= 1'b1;
            end
          end else if (!req_g) begin
            state      <= GAP;
            burst_done <= 1'b1;
          end else if (rempty) begin
            // Counters saturate so a long stall can never wrap into a false match.
            if (tmo != CMAX) tmo <= tmo + CW'(1);
            if (tmo == CW'(TMO - 1)) begin
              state      <= GAP;
              burst_done <= 1'b1;
            end
          end
        end
        GAP: begin
          grant      <= '0;
          last       <= gidx;
          burst_done <= 1'b0;
          state      <= IDLE;
        end
        default: begin
          state      <= IDLE;
          grant      <= '0;
          burst_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rd_port_arbiter.sv
// Directed bench for rd_port_arbiter with a behavioural FIFO and pop scoreboard.
module tb_rd_port_arbiter;

  logic       rclk = 1'b0;
  logic       rrst_n = 1'b0;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic [3:0] req = 4'b1111;
  logic [3:0] rdy = 4'b0000;
  logic [3:0] grant;
  logic [7:0] dout;
  logic [3:0] dvalid;
  logic       busy;
  logic       burst_done;

  logic [7:0] mem [0:63];
  int         wr_ptr = 0;
  int         rd_ptr = 0;

  int         checks = 0;
  int         passed = 0;
  int         pop_n  = 0;
  int         viol   = 0;
  logic [7:0] pop_dout [0:63];
  logic [3:0] pop_gnt  [0:63];

  rd_port_arbiter dut (
    .rclk       (rclk),
    .rrst_n     (rrst_n),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .req        (req),
    .rdy        (rdy),
    .grant      (grant),
    .dout       (dout),
    .dvalid     (dvalid),
    .busy       (busy),
    .burst_done (burst_done)
  );

  always #5 rclk = ~rclk;

  assign rempty = (rd_ptr == wr_ptr);
  assign rdata  = mem[rd_ptr % 64];

  always @(posedge rclk) begin
    if (rinc) rd_ptr <= rd_ptr + 1;
  end

  // Log every pop just before the edge that performs it.
  always @(negedge rclk) begin
    #2;
    if (rinc && rempty) viol++;
    if (rinc && pop_n < 64) begin
      pop_dout[pop_n] = dout;
      pop_gnt[pop_n]  = grant;
      pop_n++;
    end
  end

  function automatic logic [7:0] wordAt(input int i);
    return 8'((i * 37 + 5) % 256);
  endfunction

  task automatic pushWords(input int n);
    for (int j = 0; j < n; j++) begin
      mem[wr_ptr % 64] = wordAt(wr_ptr);
      wr_ptr++;
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic [3:0] r, input logic [3:0] y);
    @(negedge rclk);
    rrst_n = rst;
    req    = r;
    rdy    = y;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic checkCycle(input string tag, input logic [3:0] g, input logic ri,
                            input logic [3:0] dv, input logic bz, input logic bd);
    checkOutput({tag, ".grant"}, 32'(grant), 32'(g));
    checkOutput({tag, ".rinc"}, 32'(rinc), 32'(ri));
    checkOutput({tag, ".dvalid"}, 32'(dvalid), 32'(dv));
    checkOutput({tag, ".busy"}, 32'(busy), 32'(bz));
    checkOutput({tag, ".burst_done"}, 32'(burst_done), 32'(bd));
  endtask

  initial begin
    logic [3:0] g;
    int ph;

    // Reset held with all requests up, then first grant one cycle after release
    repeat (3) @(posedge rclk);
    applyStimulus(1'b0, 4'b1111, 4'b0000);
    checkCycle("t1_reset", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'b1111, 4'b0000);
    checkCycle("t1_release", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    applyStimulus(1'b0, 4'b0000, 4'b0000);
    checkCycle("t1_first", 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0);
    applyStimulus(1'b1, 4'b0000, 4'b0000);
    checkCycle("t1_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);

    // Round-robin over four full bursts
    pushWords(16);
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    for (int k = 0; k < 24; k++) begin
      applyStimulus(1'b1, (k == 23) ? 4'b0000 : 4'b1111, 4'b1111);
      ph = k % 6;
      g  = 4'(1 << (k / 6));
      checkCycle($sformatf("t2_c%0d", k), (ph < 5) ? g : 4'b0000, ph < 4,
                 (ph < 4) ? g : 4'b0000, ph < 5, ph == 4);
    end
    for (int i = 0; i < 16; i++)
      checkOutput($sformatf("t2_popgnt%0d", i), 32'(pop_gnt[i]), 32'(1 << (i / 4)));

    // One word then an empty stall until timeout
    pushWords(1);
    applyStimulus(1'b1, 4'b0100, 4'b0100);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, (k >= 7) ? 4'b0000 : 4'b0100, 4'b0100);
      if (k == 0)      checkCycle("t3_pop", 4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0);
      else if (k < 7)  checkCycle($sformatf("t3_stall%0d", k), 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
      else if (k == 7) checkCycle("t3_gap", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1);
      else             checkCycle("t3_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
    checkOutput("t3_pops", 32'(pop_n), 32'd17);

    // Consumer 1 drops req and rdy after two pops; index 2 wins next
    pushWords(4);
    applyStimulus(1'b1, 4'b0010, 4'b0010);
    for (int k = 0; k < 8; k++) begin
      applyStimulus(1'b1, (k < 2) ? 4'b0010 : ((k == 3 || k == 4) ? 4'b0110 : 4'b0000),
                    (k < 2) ? 4'b0010 : 4'b0100);
      case (k)
        0, 1:    checkCycle($sformatf("t4_pop%0d", k), 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0);
        2:       checkCycle("t4_drop", 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
        3:       checkCycle("t4_gap", 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b1);
        4:       checkCycle("t4_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
        5:       checkCycle("t4_next", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b0);
        6:       checkCycle("t4_gap2", 4'b0100, 1'b0, 4'b0000, 1'b1, 1'b1);
        default: checkCycle("t4_idle2", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      endcase
    end
    checkOutput("t4_pops", 32'(pop_n), 32'd19);

    // Backpressure: rdy[0] toggles, burst completes on the fourth pop
    pushWords(6);
    applyStimulus(1'b1, 4'b0001, 4'b0001);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(1'b1, (k >= 7) ? 4'b0000 : 4'b0001, (k % 2 == 0) ? 4'b0001 : 4'b0000);
      if (k < 7)       checkCycle($sformatf("t5_c%0d", k), 4'b0001, (k % 2) == 0, 4'b0001, 1'b1, 1'b0);
      else if (k == 7) checkCycle("t5_gap", 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
      else             checkCycle("t5_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    end
    checkOutput("t5_pops", 32'(pop_n), 32'd23);

    // Reset during beat 2; arbitration restarts from index 0
    pushWords(4);
    applyStimulus(1'b1, 4'b1111, 4'b1111);
    for (int k = 0; k < 9; k++) begin
      applyStimulus(k != 1, (k >= 7) ? 4'b0000 : 4'b1111, 4'b1111);
      if (k == 0)      checkCycle("t6_beat1", 4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0);
      else if (k == 1) checkCycle("t6_rst", 4'b0010, 1'b0, 4'b0000, 1'b1, 1'b0);
      else if (k == 2) checkCycle("t6_idle", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
      else if (k < 7)  checkCycle($sformatf("t6_c%0d", k), 4'b0001, 1'b1, 4'b0001, 1'b1, 1'b0);
      else if (k == 7) checkCycle("t6_gap", 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b1);
      else             checkCycle("t6_end", 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0);
    end

    // Whole-run scoreboard: every word delivered once, in order
    checkOutput("sb_pops", 32'(pop_n), 32'd28);
    for (int i = 0; i < 28; i++)
      checkOutput($sformatf("sb_word%0d", i), 32'(pop_dout[i]), 32'(wordAt(i)));
    checkOutput("rinc_while_empty", 32'(viol), 32'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
